// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: per-key synchroniser, press/release
// debounce, and one-clock press/release/long/repeat pulses paced by a shared tick.

module key_debounce_lane #(
  parameter int DEB_CYCLES    = 3,
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic clock,
  input  logic rst_n,
  input  logic tick,
  input  logic key_sync,
  output logic keyout,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W  = $clog2(LONG_CYCLES + 1);
  // Keep the repeat counter at least one bit wide even when repeat is disabled.
  localparam int REP_MAX = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  state_t            state_q, state_n;
  logic [DEB_W-1:0]  deb_q, deb_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic [REP_W-1:0]  rep_q, rep_n;
  logic              keyout_n, press_n, rel_n, long_n, rpt_n;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      rep_q       <= '0;
      keyout      <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      state_q     <= state_n;
      deb_q       <= deb_n;
      hold_q      <= hold_n;
      rep_q       <= rep_n;
      keyout      <= keyout_n;
      key_press   <= press_n;
      key_release <= rel_n;
      key_long    <= long_n;
      key_repeat  <= rpt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    deb_n   = deb_q;
    hold_n  = hold_q;
    rep_n   = rep_q;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    rpt_n   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (key_sync) begin
            if (DEB_CYCLES == 1) begin
              state_n = HELD;
              press_n = 1'b1;
              deb_n   = '0;
              hold_n  = '0;
              rep_n   = '0;
            end else begin
              state_n = PRESS_CHK;
              deb_n   = DEB_W'(1);
            end
          end
        end
        PRESS_CHK: begin
          if (!key_sync) begin
            state_n = IDLE;
            deb_n   = '0;
          end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
            state_n = HELD;
            press_n = 1'b1;
            deb_n   = '0;
            hold_n  = '0;
            rep_n   = '0;
          end else begin
            deb_n = deb_q + 1'b1;
          end
        end
        HELD: begin
          // Hold/repeat timing only advances on ticks where the key still reads high.
          if (!key_sync) begin
            if (DEB_CYCLES == 1) begin
              state_n = IDLE;
              rel_n   = 1'b1;
            end else begin
              state_n = RELEASE_CHK;
              deb_n   = DEB_W'(1);
            end
          end else if (hold_q < HOLD_W'(LONG_CYCLES)) begin
            hold_n = hold_q + 1'b1;
            if (hold_n == HOLD_W'(LONG_CYCLES)) begin
              long_n = 1'b1;
              rep_n  = '0;
            end
          end else if (REPEAT_CYCLES > 0) begin
            rep_n = rep_q + 1'b1;
            if (rep_n == REP_W'(REP_MAX)) begin
              rpt_n = 1'b1;
              rep_n = '0;
            end
          end
        end
        RELEASE_CHK: begin
          if (key_sync) begin
            state_n = HELD;
            deb_n   = '0;
          end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
            state_n = IDLE;
            rel_n   = 1'b1;
            deb_n   = '0;
          end else begin
            deb_n = deb_q + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          deb_n   = '0;
        end
      endcase
    end
    keyout_n = (state_n == HELD) || (state_n == RELEASE_CHK);
  end

endmodule

module key_debounce_multi #(
  parameter int N             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 3,
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [N-1:0] keyin,
  output logic [N-1:0] keyout,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long,
  output logic [N-1:0] key_repeat
);

  // sync_q[0] takes the raw pins; the last stage feeds the lanes.
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  key_sync;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], keyin};
  end

  assign key_sync = sync_q[SYNC_STAGES-1];

  key_debounce_lane #(
    .DEB_CYCLES   (DEB_CYCLES),
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_lane [N-1:0] (
    .clock      (clock),
    .rst_n      (rst_n),
    .tick       (tick),
    .key_sync   (key_sync),
    .keyout     (keyout),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboarded bench for key_debounce_multi: expected pulse edges are queued
// when keys are driven and matched against every output clock.

module tb_key_debounce_multi;

  localparam int N      = 4;
  localparam int K_PRS  = 0;
  localparam int K_REL  = 1;
  localparam int K_LONG = 2;
  localparam int K_REP  = 3;

  typedef struct {
    int e;
    int ch;
    int kind;
  } ev_t;

  logic         clock = 1'b0;
  logic         rst_n;
  logic         tick;
  logic [N-1:0] keyin;
  logic [N-1:0] keyout, key_press, key_release, key_long, key_repeat;

  int  edge_cnt = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  bit  sb_en = 1'b0;
  ev_t sbq[$];
  logic [N-1:0] ep, er, el, erp;

  key_debounce_multi #(
    .N(N), .SYNC_STAGES(2), .DEB_CYCLES(3), .LONG_CYCLES(8), .REPEAT_CYCLES(4)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .tick       (tick),
    .keyin      (keyin),
    .keyout     (keyout),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Scoreboard consumer: every clock, pulses must equal exactly the queued events.
  always @(negedge clock) begin
    if (sb_en) begin
      ep = '0; er = '0; el = '0; erp = '0;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].e == edge_cnt) begin
          case (sbq[i].kind)
            K_PRS:   ep[sbq[i].ch]  = 1'b1;
            K_REL:   er[sbq[i].ch]  = 1'b1;
            K_LONG:  el[sbq[i].ch]  = 1'b1;
            default: erp[sbq[i].ch] = 1'b1;
          endcase
          sbq.delete(i);
        end
      end
      n_cmp += 4;
      if (key_press !== ep) begin
        n_err++; $display("FAIL press @edge %0d: got %b want %b", edge_cnt, key_press, ep);
      end
      if (key_release !== er) begin
        n_err++; $display("FAIL release @edge %0d: got %b want %b", edge_cnt, key_release, er);
      end
      if (key_long !== el) begin
        n_err++; $display("FAIL long @edge %0d: got %b want %b", edge_cnt, key_long, el);
      end
      if (key_repeat !== erp) begin
        n_err++; $display("FAIL repeat @edge %0d: got %b want %b", edge_cnt, key_repeat, erp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic push(input int e, input int ch, input int kind);
    ev_t ev;
    ev.e = e; ev.ch = ch; ev.kind = kind;
    sbq.push_back(ev);
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge clock);
  endtask

  task automatic test_reset;
    #1;
    n_cmp += 2;
    if (keyout !== '0) begin
      n_err++; $display("FAIL reset_keyout: got %b want 0000", keyout);
    end
    if ({key_press, key_release, key_long, key_repeat} !== '0) begin
      n_err++; $display("FAIL reset_pulses: got %h want 0", {key_press, key_release, key_long, key_repeat});
    end
    keyin = 4'hF;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({keyout, key_press, key_release, key_long, key_repeat} !== '0) begin
      n_err++; $display("FAIL reset_hold: got %h want 0", {keyout, key_press, key_release, key_long, key_repeat});
    end
    keyin = '0;
    @(negedge clock);
    rst_n = 1'b1;
    sb_en = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_clean_press;
    int e0, r0;
    @(negedge clock);
    keyin[0] = 1'b1; e0 = edge_cnt + 1;
    push(e0 + 4, 0, K_PRS);
    wait_edge(e0 + 3);
    n_cmp++;
    if (keyout !== 4'b0000) begin
      n_err++; $display("FAIL clean_pre: got %b want 0000", keyout);
    end
    wait_edge(e0 + 4);
    n_cmp++;
    if (keyout !== 4'b0001) begin
      n_err++; $display("FAIL clean_keyout: got %b want 0001", keyout);
    end
    wait_edge(e0 + 5);
    keyin[0] = 1'b0; r0 = edge_cnt + 1;
    push(r0 + 4, 0, K_REL);
    wait_edge(r0 + 3);
    n_cmp++;
    if (keyout !== 4'b0001) begin
      n_err++; $display("FAIL clean_rel_pre: got %b want 0001", keyout);
    end
    wait_edge(r0 + 4);
    n_cmp++;
    if (keyout !== 4'b0000) begin
      n_err++; $display("FAIL clean_rel: got %b want 0000", keyout);
    end
    wait_edge(r0 + 6);
  endtask

  task automatic test_bounce;
    int a, f0, r0;
    @(negedge clock);
    keyin[1] = 1'b1; a = edge_cnt + 1;
    wait_edge(a + 1);
    keyin[1] = 1'b0;
    wait_edge(a + 2);
    keyin[1] = 1'b1; f0 = edge_cnt + 1;
    push(f0 + 4, 1, K_PRS);
    wait_edge(f0 + 3);
    n_cmp++;
    if (keyout !== 4'b0000) begin
      n_err++; $display("FAIL bounce_pre: got %b want 0000", keyout);
    end
    wait_edge(f0 + 4);
    n_cmp++;
    if (keyout !== 4'b0010) begin
      n_err++; $display("FAIL bounce_keyout: got %b want 0010", keyout);
    end
    keyin[1] = 1'b0; r0 = edge_cnt + 1;
    push(r0 + 4, 1, K_REL);
    wait_edge(r0 + 6);
  endtask

  task automatic test_long_repeat;
    int e0, p;
    @(negedge clock);
    keyin[2] = 1'b1; e0 = edge_cnt + 1; p = e0 + 4;
    push(p, 2, K_PRS);
    push(p + 8, 2, K_LONG);
    for (int k = 12; k <= 24; k += 4) push(p + k, 2, K_REP);
    wait_edge(p + 23);
    keyin[2] = 1'b0;
    push(p + 28, 2, K_REL);
    wait_edge(p + 27);
    n_cmp++;
    if (keyout !== 4'b0100) begin
      n_err++; $display("FAIL long_keyout: got %b want 0100", keyout);
    end
    wait_edge(p + 30);
  endtask

  task automatic test_release_glitch;
    int e0, p;
    @(negedge clock);
    keyin[3] = 1'b1; e0 = edge_cnt + 1; p = e0 + 4;
    push(p, 3, K_PRS);
    push(p + 8, 3, K_LONG);
    wait_edge(p + 9);
    keyin[3] = 1'b0;
    wait_edge(p + 10);
    keyin[3] = 1'b1;
    // Two frozen ticks (P+12, P+13) slip the cadence from P+12 to P+14.
    push(p + 14, 3, K_REP);
    push(p + 18, 3, K_REP);
    wait_edge(p + 13);
    n_cmp++;
    if (keyout !== 4'b1000) begin
      n_err++; $display("FAIL glitch_keyout: got %b want 1000", keyout);
    end
    wait_edge(p + 19);
    keyin[3] = 1'b0;
    push(p + 24, 3, K_REL);
    wait_edge(p + 24);
    n_cmp++;
    if (keyout !== 4'b0000) begin
      n_err++; $display("FAIL glitch_rel: got %b want 0000", keyout);
    end
    wait_edge(p + 26);
  endtask

  task automatic test_simultaneous;
    int e0, r0;
    @(negedge clock);
    keyin = 4'b0101; e0 = edge_cnt + 1;
    push(e0 + 4, 0, K_PRS);
    push(e0 + 4, 2, K_PRS);
    wait_edge(e0 + 4);
    n_cmp++;
    if (keyout !== 4'b0101) begin
      n_err++; $display("FAIL simul_keyout: got %b want 0101", keyout);
    end
    keyin = 4'b0000; r0 = edge_cnt + 1;
    push(r0 + 4, 0, K_REL);
    push(r0 + 4, 2, K_REL);
    wait_edge(r0 + 6);
  endtask

  task automatic test_tick_gating;
    int e0, pt, lg, rl, c;
    logic [N-1:0] prev;
    @(negedge clock);
    keyin[0] = 1'b1; e0 = edge_cnt + 1;
    tick = (e0 % 4 == 0);
    c = 0; pt = 0;
    for (int e = e0 + 2; pt == 0; e++) if (e % 4 == 0) begin c++; if (c == 3) pt = e; end
    lg = pt + 8 * 4;
    c = 0; rl = 0;
    for (int e = lg + 4; rl == 0; e++) if (e % 4 == 0) begin c++; if (c == 3) rl = e; end
    push(pt, 0, K_PRS);
    push(lg, 0, K_LONG);
    push(rl, 0, K_REL);
    prev = keyout;
    while (edge_cnt < rl + 3) begin
      @(negedge clock);
      if (edge_cnt % 4 != 0) begin
        n_cmp++;
        if (keyout !== prev) begin
          n_err++; $display("FAIL tick_hold @edge %0d: got %b want %b", edge_cnt, keyout, prev);
        end
      end
      if (edge_cnt == pt) begin
        n_cmp++;
        if (keyout !== 4'b0001) begin
          n_err++; $display("FAIL tick_keyout: got %b want 0001", keyout);
        end
      end
      prev = keyout;
      if (edge_cnt == lg + 1) keyin[0] = 1'b0;
      tick = ((edge_cnt + 1) % 4 == 0);
    end
    tick = 1'b1;
    n_cmp++;
    if (keyout !== 4'b0000) begin
      n_err++; $display("FAIL tick_rel: got %b want 0000", keyout);
    end
  endtask

  task automatic test_async_reset;
    int e0, p, r0;
    @(negedge clock);
    keyin[0] = 1'b1; e0 = edge_cnt + 1; p = e0 + 4;
    push(p, 0, K_PRS);
    push(p + 8, 0, K_LONG);
    wait_edge(p + 9);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({keyout, key_press, key_release, key_long, key_repeat} !== '0) begin
      n_err++; $display("FAIL async_rst: got %h want 0", {keyout, key_press, key_release, key_long, key_repeat});
    end
    wait_edge(p + 11);
    rst_n = 1'b1; e0 = edge_cnt + 1;
    push(e0 + 4, 0, K_PRS);
    wait_edge(e0 + 3);
    n_cmp++;
    if (keyout !== 4'b0000) begin
      n_err++; $display("FAIL rst_repress_pre: got %b want 0000", keyout);
    end
    wait_edge(e0 + 4);
    n_cmp++;
    if (keyout !== 4'b0001) begin
      n_err++; $display("FAIL rst_repress: got %b want 0001", keyout);
    end
    keyin[0] = 1'b0; r0 = edge_cnt + 1;
    push(r0 + 4, 0, K_REL);
    wait_edge(r0 + 6);
  endtask

  initial begin
    rst_n = 1'b1;
    tick  = 1'b1;
    keyin = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_release_glitch();
    test_simultaneous();
    test_tick_gating();
    test_async_reset();
    @(negedge clock);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
